// File: rtl/instr_fetch_unit.sv
// Purpose: fetches a run of instruction words from memory into a small FIFO feeding decode.
// Latency: start in cycle N -> first read in N+1, first instr_vld in N+3; one word/cycle sustained.
// Backpressure: instr_rdy low stalls the FIFO head; reads are throttled so occupancy+inflight <= DEPTH.
module instr_fetch_unit #(
  parameter int INSTR_L = 32,
  parameter int ADDR_L  = 16,
  parameter int DEPTH   = 4    // power of two, at least 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_L-1:0]  base_addr,
  input  logic [ADDR_L-1:0]  instr_cnt,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [ADDR_L-1:0]  mem_rd_addr,
  input  logic [INSTR_L-1:0] mem_rd_data,
  output logic [INSTR_L-1:0] instr_out,
  output logic               instr_vld,
  input  logic               instr_rdy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Program registers
  logic [1:0]        state_q;
  logic [ADDR_L-1:0] base_q;
  logic [ADDR_L-1:0] cnt_q;
  logic [ADDR_L-1:0] issued_q;
  logic              zero_done_q;   // done pulse owed for a zero-length program

  // Buffer registers
  logic [INSTR_L-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               inflight_q;   // a read was issued last cycle; its data is on mem_rd_data now

  logic [OCC_W:0] reserved;
  logic           push;
  logic           pop;
  logic           drain_done;

  // Read issue, handshake and status decode from the current registered state
  always_comb begin
    reserved    = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
    mem_rd_en   = (state_q == S_FETCH) && (issued_q < cnt_q) && (reserved < (OCC_W+1)'(DEPTH));
    mem_rd_addr = mem_rd_en ? (base_q + issued_q) : '0;
    push        = inflight_q;
    instr_vld   = (occ_q != '0);
    pop         = instr_vld && instr_rdy;
    instr_out   = buf_q[rd_ptr_q];
    drain_done  = (state_q == S_DRAIN) && (occ_q == '0) && !inflight_q;
    done        = drain_done || zero_done_q;
    busy        = (state_q != S_IDLE);
  end

  // Program sequencing: IDLE -> FETCH while reads remain -> DRAIN until the buffer empties
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (instr_cnt != '0) begin
              base_q   <= base_addr;
              cnt_q    <= instr_cnt;
              issued_q <= '0;
              state_q  <= S_FETCH;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (mem_rd_en) begin
            issued_q <= issued_q + 1'b1;
            if ((issued_q + 1'b1) == cnt_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO control: inflight tracks the one-cycle memory latency, pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= mem_rd_en;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage; data contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_q[wr_ptr_q] <= mem_rd_data;
    end
  end

  // The issue throttle must make a push into a full buffer impossible
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (occ_q == OCC_W'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] instr_cnt;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] instr_out;
  logic        instr_vld;
  logic        instr_rdy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [15:0] addr_q [$];
  logic [31:0] got_q  [$];
  logic [31:0] held;

  instr_fetch_unit #(.INSTR_L(32), .ADDR_L(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .instr_cnt(instr_cnt),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .instr_out(instr_out), .instr_vld(instr_vld),
    .instr_rdy(instr_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Memory model: data for the address read in one cycle appears in the next
  always @(posedge clk) mem_rd_data <= mdat(mem_rd_addr);

  // Transaction monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) addr_q.push_back(mem_rd_addr);
      if (instr_vld && instr_rdy) got_q.push_back(instr_out);
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      next_cycle();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; instr_cnt = '0; instr_rdy = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_rd_addr", {16'd0, mem_rd_addr}, 32'd0);
    check("rst_vld", {31'd0, instr_vld}, 32'd0);

    // Basic: start in the first cycle after reset release
    rst = 1'b0; start = 1'b1; base_addr = 16'h0010; instr_cnt = 16'd3;   // cycle N
    next_cycle(); start = 1'b0;                                           // N+1
    check("b_en1", {31'd0, mem_rd_en}, 32'd1);
    check("b_addr1", {16'd0, mem_rd_addr}, 32'h10);
    check("b_busy1", {31'd0, busy}, 32'd1);
    check("b_vld1", {31'd0, instr_vld}, 32'd0);
    next_cycle();                                                         // N+2
    check("b_addr2", {16'd0, mem_rd_addr}, 32'h11);
    check("b_vld2", {31'd0, instr_vld}, 32'd0);
    next_cycle();                                                         // N+3
    check("b_addr3", {16'd0, mem_rd_addr}, 32'h12);
    check("b_vld3", {31'd0, instr_vld}, 32'd1);
    check("b_out3", instr_out, mdat(16'h10));
    next_cycle();                                                         // N+4
    check("b_en4", {31'd0, mem_rd_en}, 32'd0);
    check("b_out4", instr_out, mdat(16'h11));
    next_cycle();                                                         // N+5
    check("b_out5", instr_out, mdat(16'h12));
    check("b_done5", {31'd0, done}, 32'd0);
    next_cycle();                                                         // N+6
    check("b_vld6", {31'd0, instr_vld}, 32'd0);
    check("b_done6", {31'd0, done}, 32'd1);
    next_cycle();                                                         // N+7
    check("b_done7", {31'd0, done}, 32'd0);
    check("b_busy7", {31'd0, busy}, 32'd0);

    // Backpressure: only DEPTH reads until the head is accepted
    addr_q.delete(); got_q.delete();
    instr_rdy = 1'b0; start = 1'b1; base_addr = 16'h0100; instr_cnt = 16'd8;
    next_cycle(); start = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();
    held = instr_out;
    for (int i = 0; i < 15; i++) next_cycle();
    check("bp_reads", addr_q.size(), 32'd4);
    check("bp_en_low", {31'd0, mem_rd_en}, 32'd0);
    check("bp_vld", {31'd0, instr_vld}, 32'd1);
    check("bp_stable", instr_out, held);
    check("bp_head", instr_out, mdat(16'h0100));
    instr_rdy = 1'b1;
    wait_done("bp_done", 60);
    next_cycle();
    check("bp_reads_all", addr_q.size(), 32'd8);
    check("bp_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      check("bp_order", got_q[i], mdat(16'h0100 + 16'(i)));

    // Address wrap at the top of the address space
    addr_q.delete(); got_q.delete();
    start = 1'b1; base_addr = 16'hFFFE; instr_cnt = 16'd4;
    next_cycle(); start = 1'b0;
    wait_done("w_done", 40);
    next_cycle();
    check("w_reads", addr_q.size(), 32'd4);
    check("w_a0", {16'd0, addr_q[0]}, 32'hFFFE);
    check("w_a1", {16'd0, addr_q[1]}, 32'hFFFF);
    check("w_a2", {16'd0, addr_q[2]}, 32'h0000);
    check("w_a3", {16'd0, addr_q[3]}, 32'h0001);
    check("w_out2", got_q[2], mdat(16'h0000));

    // Zero-length program
    addr_q.delete(); done_cnt = 0;
    start = 1'b1; base_addr = 16'h0040; instr_cnt = 16'd0;                // N
    next_cycle(); start = 1'b0;                                           // N+1
    check("z_done", {31'd0, done}, 32'd1);
    check("z_busy", {31'd0, busy}, 32'd0);
    check("z_en", {31'd0, mem_rd_en}, 32'd0);
    next_cycle();                                                         // N+2
    check("z_done_off", {31'd0, done}, 32'd0);
    check("z_reads", addr_q.size(), 32'd0);

    // Reset during a 10-instruction program, at the third instruction
    start = 1'b1; base_addr = 16'h0200; instr_cnt = 16'd10;               // N
    next_cycle(); start = 1'b0;                                           // N+1
    for (int i = 0; i < 4; i++) next_cycle();                             // N+5
    check("r_third", instr_out, mdat(16'h0202));
    check("r_en_before", {31'd0, mem_rd_en}, 32'd1);
    rst = 1'b1;
    next_cycle();                                                         // N+6
    rst = 1'b0;
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_en", {31'd0, mem_rd_en}, 32'd0);
    check("r_addr", {16'd0, mem_rd_addr}, 32'd0);
    check("r_vld", {31'd0, instr_vld}, 32'd0);
    check("r_done", {31'd0, done}, 32'd0);
    addr_q.delete(); got_q.delete();
    start = 1'b1; base_addr = 16'h0300; instr_cnt = 16'd2;
    next_cycle(); start = 1'b0;                                           // N+7
    check("r_dropped", {31'd0, instr_vld}, 32'd0);
    check("r_restart_addr", {16'd0, mem_rd_addr}, 32'h0300);
    wait_done("r_done2", 30);
    next_cycle();
    check("r_count", got_q.size(), 32'd2);
    check("r_out0", got_q[0], mdat(16'h0300));
    check("r_out1", got_q[1], mdat(16'h0301));

    // Long program with random backpressure and spurious starts while busy
    addr_q.delete(); got_q.delete(); done_cnt = 0;
    start = 1'b1; base_addr = 16'h0400; instr_cnt = 16'd100;
    next_cycle();
    begin
      int n = 0;
      start = 1'b0;
      while (done !== 1'b1 && n < 2000) begin
        instr_rdy = 1'($urandom_range(0, 1));
        if (busy && $urandom_range(0, 7) == 0) begin
          start = 1'b1; base_addr = 16'h0900; instr_cnt = 16'd5;
        end
        next_cycle();
        start = 1'b0;
        n++;
      end
    end
    check("rnd_done", {31'd0, done}, 32'd1);
    instr_rdy = 1'b1;
    next_cycle();
    next_cycle();
    check("rnd_idle", {31'd0, busy}, 32'd0);
    check("rnd_done_cnt", done_cnt, 32'd1);
    check("rnd_reads", addr_q.size(), 32'd100);
    check("rnd_count", got_q.size(), 32'd100);
    begin
      int bad = 0;
      for (int i = 0; i < got_q.size(); i++)
        if (got_q[i] !== mdat(16'h0400 + 16'(i))) bad++;
      check("rnd_order_bad", bad, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_L, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_L, default 16, instruction memory address and count width.
REQ-003 SHALL have parameter DEPTH, default 4, instruction buffer entries; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a fetch program.
REQ-007 SHALL have port base_addr  input  ADDR_L  first instruction address; sampled with start.
REQ-008 SHALL have port instr_cnt  input  ADDR_L  number of instructions to fetch; sampled with start.
REQ-009 SHALL have port busy  output  1  high while the state is not IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the program has completed.
REQ-011 SHALL have port mem_rd_en  output  1  instruction memory read request.
REQ-012 SHALL have port mem_rd_addr  output  ADDR_L  read address; valid while mem_rd_en is high.
REQ-013 SHALL have port mem_rd_data  input  INSTR_L  read data; valid exactly one cycle after mem_rd_en.
REQ-014 SHALL have port instr_out  output  INSTR_L  head-of-buffer instruction sent to the decode/PRU stage.
REQ-015 SHALL have port instr_vld  output  1  instr_out is valid.
REQ-016 SHALL have port instr_rdy  input  1  the downstream stage accepts instr_out.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH and DRAIN.
REQ-018 IDLE: on start with instr_cnt>0, SHALL latch base_addr and instr_cnt, clear the issue count, and go to FETCH.
REQ-019 IDLE: on start with instr_cnt==0, SHALL remain in IDLE, issue no reads, and pulse done in the next cycle.
REQ-020 FETCH: SHALL drive mem_rd_en combinationally when issued<cnt and (occupancy + inflight) < DEPTH, using current-cycle registered values.
REQ-021 Each issued read SHALL take mem_rd_addr = base + issued, modulo 2^ADDR_L, wrapping from all-ones to 0.
REQ-022 FETCH SHALL move to DRAIN in the cycle after the last read is issued.
REQ-023 DRAIN SHALL move to IDLE when the buffer is empty and no read is inflight, and SHALL pulse done for exactly one cycle in that transition cycle.
REQ-024 The buffer SHALL write mem_rd_data at the end of the cycle after each mem_rd_en; inflight is a single 1-bit flag.
REQ-025 instr_vld SHALL equal (occupancy != 0), and instr_out SHALL be the oldest entry; the buffer has no bypass.
REQ-026 A pop SHALL occur when instr_vld && instr_rdy.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-028 The flow-control rule of REQ-020 guarantees the buffer never overflows; a push to a full buffer is an assertion failure.
REQ-029 Latency SHALL be as follows: start in cycle N gives mem_rd_en in N+1 and instr_vld in N+3.
REQ-030 With instr_rdy held high, the block SHALL sustain one instruction per cycle.
REQ-031 start SHALL be ignored while busy.
REQ-032 instr_rdy SHALL be ignored while instr_vld is low.
REQ-033 instr_out SHALL be held stable while instr_vld && !instr_rdy.

Reset
REQ-034 When rst is high at a clock edge, SHALL force IDLE and set busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, instr_vld=0, occupancy=0 and inflight=0; instr_out is don't-care.
REQ-035 Reset mid-program SHALL discard buffered and inflight data; read data returning in the cycle after reset SHALL not be written.
REQ-036 After reset deasserts, the block SHALL accept start in the first cycle.

Verification
REQ-037 Basic: base_addr=0x10, instr_cnt=3, instr_rdy=1 -> mem_rd_en at N+1..N+3 (addr 0x10,0x11,0x12); instr_vld N+3..N+5 in order; done pulse at N+6.
REQ-038 Backpressure: instr_cnt=8, instr_rdy=0 for 20 cycles -> exactly DEPTH=4 reads issued, then mem_rd_en stays low and instr_out stays stable; releasing rdy delivers all 8 in order.
REQ-039 Wrap: base_addr=0xFFFE, instr_cnt=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-040 Zero count: start with instr_cnt=0 -> no mem_rd_en, busy stays 0, done pulses at N+1.
REQ-041 Reset mid-program: rst asserted at the third instruction of a 10-instruction program -> all outputs take reset values the next cycle; the returning read data is dropped; a new start works normally.
REQ-042 Random instr_rdy (50%), instr_cnt=100 -> scoreboard order matches memory contents; no overflow assertion; exactly one done pulse; start pulses while busy have no effect.
